// File: rtl/vigna_axi_pkg.sv
// Shared definitions for the Vigna AXI4-Lite arbiter: FSM states, response codes,
// port identifiers and the round-robin grant decision.
package vigna_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_XFER,
        WR_RESP
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // On a tie the port that did not win last time gets the bus.
    function automatic logic rr_pick(input logic req_i, input logic req_d, input logic last);
        if (req_i && req_d)
            return (last == PORT_I) ? PORT_D : PORT_I;
        else if (req_i)
            return PORT_I;
        else
            return PORT_D;
    endfunction

endpackage

// File: rtl/vigna_axi_arbiter.sv
// Shares one AXI4-Lite port between the Vigna instruction and data masters,
// one transaction at a time, with round-robin arbitration on ties.
module vigna_axi_arbiter
    import vigna_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                s_i_arvalid,
    output logic                s_i_arready,
    input  logic [ADDR_W-1:0]   s_i_araddr,
    input  logic [2:0]          s_i_arprot,
    output logic                s_i_rvalid,
    input  logic                s_i_rready,
    output logic [DATA_W-1:0]   s_i_rdata,
    output logic [1:0]          s_i_rresp,

    input  logic                s_d_arvalid,
    output logic                s_d_arready,
    input  logic [ADDR_W-1:0]   s_d_araddr,
    input  logic [2:0]          s_d_arprot,
    output logic                s_d_rvalid,
    input  logic                s_d_rready,
    output logic [DATA_W-1:0]   s_d_rdata,
    output logic [1:0]          s_d_rresp,
    input  logic                s_d_awvalid,
    output logic                s_d_awready,
    input  logic [ADDR_W-1:0]   s_d_awaddr,
    input  logic [2:0]          s_d_awprot,
    input  logic                s_d_wvalid,
    output logic                s_d_wready,
    input  logic [DATA_W-1:0]   s_d_wdata,
    input  logic [DATA_W/8-1:0] s_d_wstrb,
    output logic                s_d_bvalid,
    input  logic                s_d_bready,
    output logic [1:0]          s_d_bresp,

    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [2:0]          m_arprot,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [2:0]          m_awprot,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [1:0]          m_bresp
);

    arb_state_t state, state_n;
    logic       grant, grant_n;
    logic       last, last_n;
    logic       aw_done, aw_done_n;
    logic       w_done, w_done_n;
    logic       req_i, req_d;
    logic       aw_hs, w_hs;

    assign req_i = s_i_arvalid;
    assign req_d = s_d_awvalid | s_d_wvalid | s_d_arvalid;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;

    // last starts at D so the instruction port wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            grant   <= PORT_I;
            last    <= PORT_D;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            last    <= last_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        last_n    = last;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    grant_n = rr_pick(req_i, req_d, last);
                    last_n  = grant_n;
                    if (grant_n == PORT_D && (s_d_awvalid || s_d_wvalid))
                        state_n = WR_XFER;
                    else
                        state_n = RD_ADDR;
                end
            end
            RD_ADDR: if (m_arvalid && m_arready) state_n = RD_DATA;
            RD_DATA: if (m_rvalid && m_rready) state_n = IDLE;
            WR_XFER: begin
                // AW and W may land in either order, so a flag or a live handshake counts.
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_n   = WR_RESP;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end else begin
                    aw_done_n = aw_done | aw_hs;
                    w_done_n  = w_done | w_hs;
                end
            end
            WR_RESP: if (m_bvalid && m_bready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        s_i_arready = 1'b0;
        s_i_rvalid  = 1'b0;
        s_i_rdata   = '0;
        s_i_rresp   = '0;
        s_d_arready = 1'b0;
        s_d_rvalid  = 1'b0;
        s_d_rdata   = '0;
        s_d_rresp   = '0;
        s_d_awready = 1'b0;
        s_d_wready  = 1'b0;
        s_d_bvalid  = 1'b0;
        s_d_bresp   = '0;
        m_arvalid   = 1'b0;
        m_araddr    = '0;
        m_arprot    = '0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_awaddr    = '0;
        m_awprot    = '0;
        m_wvalid    = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_bready    = 1'b0;
        case (state)
            RD_ADDR: begin
                if (grant == PORT_I) begin
                    m_arvalid   = s_i_arvalid;
                    m_araddr    = s_i_araddr;
                    m_arprot    = s_i_arprot;
                    s_i_arready = m_arready;
                end else begin
                    m_arvalid   = s_d_arvalid;
                    m_araddr    = s_d_araddr;
                    m_arprot    = s_d_arprot;
                    s_d_arready = m_arready;
                end
            end
            RD_DATA: begin
                if (grant == PORT_I) begin
                    s_i_rvalid = m_rvalid;
                    s_i_rdata  = m_rdata;
                    s_i_rresp  = m_rresp;
                    m_rready   = s_i_rready;
                end else begin
                    s_d_rvalid = m_rvalid;
                    s_d_rdata  = m_rdata;
                    s_d_rresp  = m_rresp;
                    m_rready   = s_d_rready;
                end
            end
            WR_XFER: begin
                m_awvalid   = s_d_awvalid & ~aw_done;
                m_awaddr    = s_d_awaddr;
                m_awprot    = s_d_awprot;
                s_d_awready = m_awready & ~aw_done;
                m_wvalid    = s_d_wvalid & ~w_done;
                m_wdata     = s_d_wdata;
                m_wstrb     = s_d_wstrb;
                s_d_wready  = m_wready & ~w_done;
            end
            WR_RESP: begin
                s_d_bvalid = m_bvalid;
                s_d_bresp  = m_bresp;
                m_bready   = s_d_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vigna_axi_arbiter.sv
// Scoreboard bench for vigna_axi_arbiter: directed master stimulus, a simple
// zero-wait slave model, and a monitor that checks every handshake in order.
module tb_vigna_axi_arbiter;
    import vigna_axi_pkg::*;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [2:0]  prot;
    } addr_exp_t;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
        logic [1:0]  resp;
    } resp_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wdat_exp_t;

    localparam logic [1:0] K_AR = 2'd0, K_AW = 2'd1;
    localparam logic [1:0] K_IR = 2'd0, K_DR = 2'd1, K_DB = 2'd2;

    logic        clk, resetn;
    logic        s_i_arvalid, s_i_arready, s_i_rvalid, s_i_rready;
    logic [31:0] s_i_araddr, s_i_rdata;
    logic [2:0]  s_i_arprot;
    logic [1:0]  s_i_rresp;
    logic        s_d_arvalid, s_d_arready, s_d_rvalid, s_d_rready;
    logic [31:0] s_d_araddr, s_d_rdata;
    logic [2:0]  s_d_arprot;
    logic [1:0]  s_d_rresp;
    logic        s_d_awvalid, s_d_awready, s_d_wvalid, s_d_wready, s_d_bvalid, s_d_bready;
    logic [31:0] s_d_awaddr, s_d_wdata;
    logic [2:0]  s_d_awprot;
    logic [3:0]  s_d_wstrb;
    logic [1:0]  s_d_bresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [31:0] m_araddr, m_rdata;
    logic [2:0]  m_arprot;
    logic [1:0]  m_rresp;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_awaddr, m_wdata;
    logic [2:0]  m_awprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;

    int checks = 0;
    int errors = 0;

    addr_exp_t addr_q[$];
    resp_exp_t resp_q[$];
    wdat_exp_t wdat_q[$];

    logic        ar_ready_en = 1'b1;
    logic        r_hold = 1'b0;
    logic [1:0]  r_resp_cfg = RESP_OKAY;

    vigna_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .s_i_arvalid(s_i_arvalid), .s_i_arready(s_i_arready), .s_i_araddr(s_i_araddr), .s_i_arprot(s_i_arprot),
        .s_i_rvalid(s_i_rvalid), .s_i_rready(s_i_rready), .s_i_rdata(s_i_rdata), .s_i_rresp(s_i_rresp),
        .s_d_arvalid(s_d_arvalid), .s_d_arready(s_d_arready), .s_d_araddr(s_d_araddr), .s_d_arprot(s_d_arprot),
        .s_d_rvalid(s_d_rvalid), .s_d_rready(s_d_rready), .s_d_rdata(s_d_rdata), .s_d_rresp(s_d_rresp),
        .s_d_awvalid(s_d_awvalid), .s_d_awready(s_d_awready), .s_d_awaddr(s_d_awaddr), .s_d_awprot(s_d_awprot),
        .s_d_wvalid(s_d_wvalid), .s_d_wready(s_d_wready), .s_d_wdata(s_d_wdata), .s_d_wstrb(s_d_wstrb),
        .s_d_bvalid(s_d_bvalid), .s_d_bready(s_d_bready), .s_d_bresp(s_d_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not matched by the scoreboard at %0t", name, $time);
    endtask

    task automatic exp_read(input logic port, input logic [31:0] addr, input logic [2:0] prot,
                            input logic [31:0] data, input logic [1:0] resp);
        addr_q.push_back('{kind: K_AR, addr: addr, prot: prot});
        resp_q.push_back('{kind: (port == PORT_D) ? K_DR : K_IR, data: data, resp: resp});
    endtask

    task automatic exp_write(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] resp);
        addr_q.push_back('{kind: K_AW, addr: addr, prot: prot});
        wdat_q.push_back('{data: data, strb: strb});
        resp_q.push_back('{kind: K_DB, data: 32'h0, resp: resp});
    endtask

    task automatic i_read(input logic [31:0] addr, input logic [2:0] prot);
        int n = 0;
        s_i_araddr = addr; s_i_arprot = prot; s_i_arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_i_arready && n < 100);
        if (!s_i_arready) fail_event("i_ar_timeout");
        @(posedge clk); #1;
        s_i_arvalid = 1'b0; s_i_araddr = '0; s_i_arprot = '0;
    endtask

    task automatic d_read(input logic [31:0] addr, input logic [2:0] prot);
        int n = 0;
        s_d_araddr = addr; s_d_arprot = prot; s_d_arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_d_arready && n < 100);
        if (!s_d_arready) fail_event("d_ar_timeout");
        @(posedge clk); #1;
        s_d_arvalid = 1'b0; s_d_araddr = '0; s_d_arprot = '0;
    endtask

    task automatic d_write(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay, input int w_delay);
        fork
            begin
                int na = 0;
                repeat (aw_delay) begin @(posedge clk); #1; end
                s_d_awaddr = addr; s_d_awprot = prot; s_d_awvalid = 1'b1;
                do begin @(negedge clk); na++; end while (!s_d_awready && na < 100);
                if (!s_d_awready) fail_event("d_aw_timeout");
                @(posedge clk); #1;
                s_d_awvalid = 1'b0; s_d_awaddr = '0;
            end
            begin
                int nw = 0;
                repeat (w_delay) begin @(posedge clk); #1; end
                s_d_wdata = data; s_d_wstrb = strb; s_d_wvalid = 1'b1;
                do begin @(negedge clk); nw++; end while (!s_d_wready && nw < 100);
                if (!s_d_wready) fail_event("d_w_timeout");
                @(posedge clk); #1;
                s_d_wvalid = 1'b0; s_d_wdata = '0; s_d_wstrb = '0;
            end
        join
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((resp_q.size() != 0 || addr_q.size() != 0) && n < 200) begin
            @(posedge clk); n++;
        end
        if (n >= 200) fail_event("drain_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Slave model: AR/AW/W always accepted (AR gated by ar_ready_en), R and B one cycle later.
    always begin : slave
        logic hs_ar, hs_r, hs_aw, hs_w, hs_b, aw_seen, w_seen;
        logic [31:0] ar_lat;
        aw_seen = 1'b0; w_seen = 1'b0; ar_lat = '0;
        forever begin
            @(negedge clk);
            hs_ar = m_arvalid && m_arready;
            hs_r  = m_rvalid && m_rready;
            hs_aw = m_awvalid && m_awready;
            hs_w  = m_wvalid && m_wready;
            hs_b  = m_bvalid && m_bready;
            if (hs_ar) ar_lat = m_araddr;
            @(posedge clk); #1;
            if (!resetn) begin
                m_rvalid = 1'b0; m_bvalid = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
            end else begin
                if (hs_r) m_rvalid = 1'b0;
                if (hs_ar && !r_hold) begin
                    m_rvalid = 1'b1;
                    m_rdata  = {16'hCAFE, ar_lat[15:0]};
                    m_rresp  = r_resp_cfg;
                end
                if (hs_b) m_bvalid = 1'b0;
                if (hs_aw) aw_seen = 1'b1;
                if (hs_w)  w_seen  = 1'b1;
                if (aw_seen && w_seen) begin
                    m_bvalid = 1'b1; m_bresp = RESP_OKAY; aw_seen = 1'b0; w_seen = 1'b0;
                end
            end
            m_arready = ar_ready_en;
        end
    end

    // Monitor: every handshake seen on either side is matched against the expected queues.
    always @(negedge clk) begin : monitor
        addr_exp_t ea;
        resp_exp_t er;
        wdat_exp_t ew;
        if (resetn) begin
            if (m_arvalid && m_arready) begin
                if (addr_q.size() == 0) fail_event("ar_unexpected");
                else begin
                    ea = addr_q.pop_front();
                    check_output("ar_kind", 64'(K_AR), 64'(ea.kind));
                    check_output("ar_addr", 64'(m_araddr), 64'(ea.addr));
                    check_output("ar_prot", 64'(m_arprot), 64'(ea.prot));
                end
            end
            if (m_awvalid && m_awready) begin
                if (addr_q.size() == 0) fail_event("aw_unexpected");
                else begin
                    ea = addr_q.pop_front();
                    check_output("aw_kind", 64'(K_AW), 64'(ea.kind));
                    check_output("aw_addr", 64'(m_awaddr), 64'(ea.addr));
                end
            end
            if (m_wvalid && m_wready) begin
                if (wdat_q.size() == 0) fail_event("w_unexpected");
                else begin
                    ew = wdat_q.pop_front();
                    check_output("w_data_strb", 64'({m_wstrb, m_wdata}), 64'({ew.strb, ew.data}));
                end
            end
            if (s_i_rvalid || s_d_rvalid)
                check_output("r_exclusive", 64'(s_i_rvalid & s_d_rvalid), 64'(0));
            if ((s_i_rvalid && s_i_rready) || (s_d_rvalid && s_d_rready)) begin
                if (resp_q.size() == 0) fail_event("r_unexpected");
                else begin
                    er = resp_q.pop_front();
                    if (s_i_rvalid) begin
                        check_output("r_port", 64'(K_IR), 64'(er.kind));
                        check_output("i_rdata_rresp", 64'({s_i_rresp, s_i_rdata}), 64'({er.resp, er.data}));
                    end else begin
                        check_output("r_port", 64'(K_DR), 64'(er.kind));
                        check_output("d_rdata_rresp", 64'({s_d_rresp, s_d_rdata}), 64'({er.resp, er.data}));
                    end
                end
            end
            if (s_d_bvalid && s_d_bready) begin
                if (resp_q.size() == 0) fail_event("b_unexpected");
                else begin
                    er = resp_q.pop_front();
                    check_output("b_kind", 64'(K_DB), 64'(er.kind));
                    check_output("d_bresp", 64'(s_d_bresp), 64'(er.resp));
                end
            end
        end
    end

    initial begin : stimulus
        resetn = 1'b0;
        s_i_arvalid = 1'b1; s_i_araddr = 32'h0000_0100; s_i_arprot = '0; s_i_rready = 1'b1;
        s_d_arvalid = 1'b0; s_d_araddr = '0; s_d_arprot = '0; s_d_rready = 1'b1;
        s_d_awvalid = 1'b0; s_d_awaddr = '0; s_d_awprot = '0;
        s_d_wvalid = 1'b0; s_d_wdata = '0; s_d_wstrb = '0; s_d_bready = 1'b1;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = '0;
        #1;
        check_output("rst_handshakes",
            64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, s_i_arready, s_i_rvalid,
                 s_d_arready, s_d_rvalid, s_d_awready, s_d_wready, s_d_bvalid}), 64'(0));
        check_output("rst_araddr", 64'(m_araddr), 64'(0));
        s_i_arvalid = 1'b0; s_i_araddr = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // First tie after reset goes to I, then D; a second tie repeats the pattern.
        exp_read(PORT_I, 32'h100, 3'b000, 32'hCAFE_0100, RESP_OKAY);
        exp_read(PORT_D, 32'h200, 3'b000, 32'hCAFE_0200, RESP_OKAY);
        fork i_read(32'h100, 3'b000); d_read(32'h200, 3'b000); join
        wait_drain();
        exp_read(PORT_I, 32'h104, 3'b000, 32'hCAFE_0104, RESP_OKAY);
        exp_read(PORT_D, 32'h204, 3'b000, 32'hCAFE_0204, RESP_OKAY);
        fork i_read(32'h104, 3'b000); d_read(32'h204, 3'b000); join
        wait_drain();

        r_resp_cfg = RESP_SLVERR;
        exp_read(PORT_I, 32'h40, 3'b101, 32'hCAFE_0040, RESP_SLVERR);
        i_read(32'h40, 3'b101);
        wait_drain();
        r_resp_cfg = RESP_OKAY;

        // I was granted last, so D wins this tie.
        exp_read(PORT_D, 32'h280, 3'b000, 32'hCAFE_0280, RESP_OKAY);
        exp_read(PORT_I, 32'h180, 3'b000, 32'hCAFE_0180, RESP_OKAY);
        fork i_read(32'h180, 3'b000); d_read(32'h280, 3'b000); join
        wait_drain();

        exp_write(32'h80, 3'b000, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
        fork
            d_write(32'h80, 3'b000, 32'hDEAD_BEEF, 4'hF, 3, 1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check_output("wr_no_early_resp", 64'(m_bready), 64'(0));
                end
            end
        join
        wait_drain();

        r_resp_cfg = RESP_DECERR;
        exp_write(32'h10, 3'b010, 32'h1234_5678, 4'h3, RESP_OKAY);
        exp_read(PORT_D, 32'h14, 3'b000, 32'hCAFE_0014, RESP_DECERR);
        fork d_write(32'h10, 3'b010, 32'h1234_5678, 4'h3, 0, 0); d_read(32'h14, 3'b000); join
        wait_drain();
        r_resp_cfg = RESP_OKAY;

        ar_ready_en = 1'b0; m_arready = 1'b0; s_i_rready = 1'b0;
        exp_read(PORT_I, 32'h500, 3'b000, 32'hCAFE_0500, RESP_OKAY);
        exp_read(PORT_D, 32'h600, 3'b000, 32'hCAFE_0600, RESP_OKAY);
        fork
            i_read(32'h500, 3'b000);
            begin @(posedge clk); #1; d_read(32'h600, 3'b000); end
            begin
                int n = 0;
                @(posedge clk);
                repeat (5) begin
                    @(negedge clk);
                    check_output("bp_ar_stable", 64'({m_arvalid, s_d_arready, m_araddr}), 64'({2'b10, 32'h500}));
                end
                @(posedge clk); #1;
                ar_ready_en = 1'b1; m_arready = 1'b1;
                do begin @(negedge clk); n++; end while (!m_rvalid && n < 100);
                if (!m_rvalid) fail_event("bp_rvalid_timeout");
                repeat (3) begin
                    check_output("bp_r_held", 64'({m_rready, s_i_rvalid, s_d_rvalid}), 64'(3'b010));
                    @(negedge clk);
                end
                @(posedge clk); #1;
                s_i_rready = 1'b1;
            end
        join
        wait_drain();

        r_hold = 1'b1;
        addr_q.push_back('{kind: K_AR, addr: 32'h300, prot: 3'b000});
        i_read(32'h300, 3'b000);
        #1;
        check_output("mid_rd_rready_before", 64'(m_rready), 64'(1));
        resetn = 1'b0;
        #1;
        check_output("mid_rd_reset", 64'({m_rready, s_i_arready, m_arvalid}), 64'(0));
        addr_q.delete(); resp_q.delete(); wdat_q.delete();
        r_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        exp_read(PORT_I, 32'h340, 3'b000, 32'hCAFE_0340, RESP_OKAY);
        i_read(32'h340, 3'b000);
        wait_drain();

        check_output("queues_empty", 64'(addr_q.size() + resp_q.size() + wdat_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vigna_axi_arbiter.md
# vigna_axi_arbiter

Two-port AXI4-Lite interconnect arbiter that shares one AXI4-Lite memory port between the Vigna instruction-fetch master (read-only) and data master (read/write), for single-memory systems. Sits between the core's AXI4-Lite wrapper and the memory/peripheral fabric. Exactly one transaction is outstanding on the shared port at a time, and reads are granted round-robin between the two ports.

## Interface
- ADDR_W, 32: address width on all ports.
- DATA_W, 32: data width; strobe width is DATA_W/8.
- clk  in  1  single clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_i_arvalid/arready/araddr/arprot  in/out/in/in  1/1/ADDR_W/3  I-port read address.
- s_i_rvalid/rready/rdata/rresp  out/in/out/out  1/1/DATA_W/2  I-port read data.
- s_d_arvalid/arready/araddr/arprot  in/out/in/in  1/1/ADDR_W/3  D-port read address.
- s_d_rvalid/rready/rdata/rresp  out/in/out/out  1/1/DATA_W/2  D-port read data.
- s_d_awvalid/awready/awaddr/awprot  in/out/in/in  1/1/ADDR_W/3  D-port write address.
- s_d_wvalid/wready/wdata/wstrb  in/out/in/in  1/1/DATA_W/DATA_W/8  D-port write data.
- s_d_bvalid/bready/bresp  out/in/out  1/1/2  D-port write response.
- m_arvalid/arready/araddr/arprot  out/in/out/out  1/1/ADDR_W/3  shared read address.
- m_rvalid/rready/rdata/rresp  in/out/in/in  1/1/DATA_W/2  shared read data.
- m_awvalid/awready/awaddr/awprot, m_wvalid/wready/wdata/wstrb, m_bvalid/bready/bresp  master write channels, mirror of D-port directions.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP. Registers: state, grant (I or D), last (last granted port), aw_done, w_done.
- IDLE requests: reqI = s_i_arvalid; reqD = s_d_awvalid | s_d_wvalid | s_d_arvalid.
- Only one port requesting: grant it. Both requesting: grant the port != last. last updates on every grant.
- D granted with write pending (awvalid or wvalid): go to WR_XFER. Write has priority over D read if both are asserted. Otherwise go to RD_ADDR.
- RD_ADDR: m_ar* driven from the granted port. The granted s_*_arready = m_arready; the other port's arready = 0. Go to RD_DATA on m_arvalid & m_arready.
- RD_DATA: m_r* routed to the granted port only. m_rready = granted s_*_rready. Go to IDLE on the R handshake.
- WR_XFER: m_aw*/m_w* driven from D. m_awvalid = s_d_awvalid & !aw_done; m_wvalid = s_d_wvalid & !w_done. Each handshake sets its done flag; AW and W may complete in either order or in the same cycle. Go to WR_RESP when both are done (the flag or the current-cycle handshake), and clear both flags.
- WR_RESP: m_b* routed to D. Go to IDLE on the B handshake.
- rresp/bresp (including SLVERR/DECERR) and prot are passed unmodified. The arbiter never generates a response itself.
- All non-granted ready/valid outputs are 0. Data outputs of idle channels are don't-care but are driven to 0.

## Timing
- Reset (async assert): state=IDLE, last=D (so I wins the first tie), flags=0. Every valid/ready output is 0 immediately, since outputs decode from state.
- Reset mid-transaction abandons the transfer. Surrounding masters and slaves are reset by the same signal.
- Arbitration costs 1 cycle: a request seen in IDLE at edge N is presented on m_ar*/m_aw* from cycle N+1.
- Address, data and response paths are combinational pass-through in their state. Each handshake completes in the same cycle the downstream ready/valid arrives.
- Minimum read: 3 cycles from arvalid (IDLE, RD_ADDR, RD_DATA) with zero-wait slaves. Minimum write: 3 cycles.
- Back-to-back: IDLE is always visited between transactions, so the next grant decision happens the cycle after R/B completes.
- No combinational path from any m_*ready to any m_*valid.
- Requests arriving in non-IDLE states are held (no ready) until IDLE.

## Structure
- Shared package/header vigna_axi_pkg: state encodings, AXI resp constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), port-id constants PORT_I/PORT_D.
- Single module. The round-robin decision is a small function, not a sub-module.

## Test plan
- Reset mid-read: assert resetn=0 while in RD_DATA -> m_rready=0 and s_i_arready=0 in the same cycle; after release, state IDLE and an I fetch proceeds normally.
- Simultaneous requests after reset: I araddr 0x100 and D araddr 0x200 in the same cycle -> I granted first (m_araddr=0x100), then D (0x200). Repeat the tie -> grants alternate I, D, I, D.
- D write with W before AW: wvalid at cycle 1, awvalid at cycle 3 (awaddr 0x80, wdata 0xDEADBEEF, wstrb 4'hF) -> each handshake exactly once; WR_RESP only after both; s_d_bvalid follows m_bvalid.
- Error pass-through: slave returns rresp=2'b10 for I fetch 0x40 -> s_i_rresp=2'b10, s_d_rvalid stays 0.
- Backpressure: m_arready low for 5 cycles, then s_i_rready low for 3 cycles after m_rvalid -> m_araddr stable throughout, exactly one AR and one R handshake, no grant change.
- D with awvalid and arvalid together: write to 0x10 completes before read from 0x14 is issued.
